// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory request/ack, issue handshake, decoded fields and branch redirect
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        opcode;
  logic [2:0]        rs;
  logic [2:0]        rt;
  logic [2:0]        rd;
  logic [6:0]        imm;
  logic [ADDR_W-1:0] instr_pc;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  modport master (
    output imem_req, imem_addr, instr_valid, opcode, rs, rt, rd, imm, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, br_valid, br_target
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, opcode, rs, rt, rd, imm, instr_pc,
    output imem_ack, imem_rdata, instr_ready, br_valid, br_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR fetch stage with req/ack memory port and branch redirect.
// Define PREFETCH_BUF_EN to replace the single IR with a 2-entry prefetch FIFO.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);
  logic [ADDR_W-1:0] pc, addr, pc_inc, ipc;
  logic [DATA_W-1:0] ir;
  logic              req, valid, discard, ack;
  assign pc_inc = pc + ADDR_W'(1);
  assign ack = req & bus.imem_ack;
  assign bus.imem_req = req;
  assign bus.imem_addr = addr;
  assign bus.instr_valid = valid;
  assign bus.instr_pc = ipc;
  assign bus.opcode = ir[15:13];
  assign bus.rs = ir[12:10];
  assign bus.rt = ir[9:7];
  assign bus.rd = ir[6:4];
  assign bus.imm = ir[6:0];
`ifdef PREFETCH_BUF_EN
  logic [DATA_W-1:0] q_word [2];
  logic [ADDR_W-1:0] q_pc [2];
  logic              rd_ptr, push, pop;
  logic [1:0]        cnt, cnt_n;
  assign push = ack & ~discard & ~bus.br_valid;
  assign pop = valid & bus.instr_ready & ~bus.br_valid;
  assign cnt_n = cnt + 2'(push) - 2'(pop);
  assign valid = cnt != 2'd0;
  assign ir = q_word[rd_ptr];
  assign ipc = q_pc[rd_ptr];
  // cnt holds filled entries; a raised req is the one in-flight slot, so req drops at cnt=2
  always_ff @(posedge clk)
    if (reset) begin
      pc <= RESET_PC;
      addr <= RESET_PC;
      req <= 1'b0;
      discard <= 1'b0;
      cnt <= '0;
      rd_ptr <= 1'b0;
      q_word <= '{default: '0};
      q_pc <= '{default: '0};
    end else if (bus.br_valid) begin
      cnt <= '0;
      rd_ptr <= 1'b0;
      req <= 1'b1;
      pc <= bus.br_target;
      if (req && !ack) discard <= 1'b1;
      else begin
        addr <= bus.br_target;
        discard <= 1'b0;
      end
    end else begin
      if (ack && discard) begin
        discard <= 1'b0;
        addr <= pc;
      end
      if (push) begin
        q_word[rd_ptr ^ cnt[0]] <= bus.imem_rdata;
        q_pc[rd_ptr ^ cnt[0]] <= addr;
        pc <= pc_inc;
        addr <= pc_inc;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt_n;
      req <= cnt_n != 2'd2;
    end
`else
  typedef enum logic {FETCH, HOLD} state_t;
  state_t state;
  // a redirect during an outstanding request keeps addr until the ack, then drops that word
  always_ff @(posedge clk)
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      addr <= RESET_PC;
      req <= 1'b0;
      valid <= 1'b0;
      discard <= 1'b0;
      ir <= '0;
      ipc <= '0;
    end else if (state == HOLD) begin
      if (bus.br_valid || bus.instr_ready) begin
        state <= FETCH;
        valid <= 1'b0;
        req <= 1'b1;
      end
      if (bus.br_valid) begin
        pc <= bus.br_target;
        addr <= bus.br_target;
      end
    end else if (bus.br_valid) begin
      req <= 1'b1;
      pc <= bus.br_target;
      if (req && !ack) discard <= 1'b1;
      else begin
        addr <= bus.br_target;
        discard <= 1'b0;
      end
    end else begin
      req <= 1'b1;
      if (ack && discard) begin
        discard <= 1'b0;
        addr <= pc;
      end else if (ack) begin
        ir <= bus.imem_rdata;
        ipc <= addr;
        pc <= pc_inc;
        addr <= pc_inc;
        valid <= 1'b1;
        req <= 1'b0;
        state <= HOLD;
      end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized latency/ready/branch traffic
// checked against an accepted-instruction stream model (sequential PCs, restart at br_target).
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) b0 ();
  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) b1 ();
  instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00)) u0 (.clk(clk), .reset(reset), .bus(b0));
  instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'hFE)) u1 (.clk(clk), .reset(reset), .bus(b1));
`ifdef PREFETCH_BUF_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif
  logic [15:0] mem [256];
  int checks = 0, errors = 0, cyc = 0, ack_cyc = -1;
  int fixed_lat = 1;
  bit force_ack = 1'b0;
  int resp_cnt = 0, resp_need = -1;
  logic [7:0] resp_held = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory model for u0: acks after a per-request latency, checks address stays put while pending
  initial begin
    b0.imem_ack = 1'b0;
    b0.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        b0.imem_ack = 1'b1;
        b0.imem_rdata = mem[b0.imem_addr];
        resp_cnt = 0;
        resp_need = -1;
      end else if (!b0.imem_req) begin
        b0.imem_ack = 1'b0;
        resp_cnt = 0;
        resp_need = -1;
      end else begin
        if (resp_need < 0) begin
          resp_need = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
          resp_held = b0.imem_addr;
        end else begin
          checks++;
          if (b0.imem_addr !== resp_held) begin
            errors++;
            $display("FAIL addr_stable got=%h exp=%h", b0.imem_addr, resp_held);
          end
        end
        if (resp_cnt == resp_need) begin
          b0.imem_ack = 1'b1;
          b0.imem_rdata = mem[b0.imem_addr];
          ack_cyc = cyc;
          resp_cnt = 0;
          resp_need = -1;
        end else begin
          b0.imem_ack = 1'b0;
          resp_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({b0.imem_req, b0.instr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_req_valid got=%b exp=00", {b0.imem_req, b0.instr_valid});
    end
    checks++;
    if ({b0.opcode, b0.rs, b0.rt, b0.rd, b0.imm, b0.instr_pc} !== 27'd0) begin
      errors++;
      $display("FAIL reset_fields got=%h exp=0", {b0.opcode, b0.rs, b0.rt, b0.rd, b0.imm, b0.instr_pc});
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({b0.imem_req, b0.imem_addr} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL first_req got=%b/%h exp=1/00", b0.imem_req, b0.imem_addr);
    end
  endtask

  task automatic test_first_fetch();
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (b0.instr_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL first_valid_timeout got=0 exp=1");
    end
    checks++;
    if (cyc !== ack_cyc + 1) begin
      errors++;
      $display("FAIL ack_latency got=%0d exp=%0d", cyc, ack_cyc + 1);
    end
    checks++;
    if ({b0.opcode, b0.rs, b0.rt, b0.rd} !== {3'b100, 3'd2, 3'd4, 3'd5}) begin
      errors++;
      $display("FAIL first_fields got=%b/%0d/%0d/%0d exp=100/2/4/5", b0.opcode, b0.rs, b0.rt, b0.rd);
    end
    checks++;
    if ({b0.imm, b0.instr_pc} !== {7'h50, 8'h00}) begin
      errors++;
      $display("FAIL first_imm_pc got=%h/%h exp=50/00", b0.imm, b0.instr_pc);
    end
  endtask

  task automatic test_hold();
    logic [26:0] snap;
    snap = {b0.opcode, b0.rs, b0.rt, b0.rd, b0.imm, b0.instr_pc};
    b0.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({b0.instr_valid, b0.opcode, b0.rs, b0.rt, b0.rd, b0.imm, b0.instr_pc} !== {1'b1, snap}) begin
        errors++;
        $display("FAIL hold_stable got=%b/%h exp=1/%h", b0.instr_valid,
                 {b0.opcode, b0.rs, b0.rt, b0.rd, b0.imm, b0.instr_pc}, snap);
      end
    end
    checks++;
    if (b0.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL hold_req got=%b exp=0", b0.imem_req);
    end
  endtask

  task automatic test_branch_hold();
    bit found = 1'b0;
    logic [15:0] w;
    w = mem[8'h40];
    b0.br_valid = 1'b1;
    b0.br_target = 8'h40;
    b0.instr_ready = 1'b1;
    tick();
    b0.br_valid = 1'b0;
    b0.instr_ready = 1'b0;
    checks++;
    if (b0.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL br_hold_valid got=%b exp=0", b0.instr_valid);
    end
    checks++;
    if ({b0.imem_req, b0.imem_addr} !== {1'b1, 8'h40}) begin
      errors++;
      $display("FAIL br_hold_addr got=%b/%h exp=1/40", b0.imem_req, b0.imem_addr);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (b0.instr_valid) found = 1'b1;
    end
    checks++;
    if ({found, b0.instr_pc} !== {1'b1, 8'h40}) begin
      errors++;
      $display("FAIL br_hold_next_pc got=%b/%h exp=1/40", found, b0.instr_pc);
    end
    checks++;
    if ({b0.opcode, b0.rs, b0.rt, b0.rd, b0.imm} !== {w[15:13], w[12:10], w[9:7], w[6:4], w[6:0]}) begin
      errors++;
      $display("FAIL br_hold_fields got=%h exp=%h", {b0.opcode, b0.rs, b0.rt, b0.rd, b0.imm},
               {w[15:13], w[12:10], w[9:7], w[6:4], w[6:0]});
    end
    b0.instr_ready = 1'b1;
    tick();
    b0.instr_ready = 1'b0;
  endtask

  task automatic test_branch_wait();
    bit found = 1'b0;
    logic [15:0] w;
    w = mem[8'h20];
    fixed_lat = 3;
    b0.instr_ready = 1'b0;
    b0.br_valid = 1'b1;
    b0.br_target = 8'h05;
    tick();
    b0.br_valid = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (b0.imem_req && b0.imem_addr === 8'h05) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL br_wait_reach5 got=%h exp=05", b0.imem_addr);
    end
    tick();
    b0.br_valid = 1'b1;
    b0.br_target = 8'h20;
    tick();
    b0.br_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (b0.imem_req && b0.imem_addr !== 8'h05 && b0.imem_addr !== 8'h20) begin
        checks++;
        errors++;
        $display("FAIL br_wait_addr got=%h exp=05_or_20", b0.imem_addr);
      end
      tick();
      if (b0.instr_valid) found = 1'b1;
    end
    checks++;
    if ({found, b0.instr_pc} !== {1'b1, 8'h20}) begin
      errors++;
      $display("FAIL br_wait_pc got=%b/%h exp=1/20", found, b0.instr_pc);
    end
    checks++;
    if ({b0.opcode, b0.imm} !== {w[15:13], w[6:0]}) begin
      errors++;
      $display("FAIL br_wait_fields got=%h exp=%h", {b0.opcode, b0.imm}, {w[15:13], w[6:0]});
    end
    b0.instr_ready = 1'b1;
    tick();
    b0.instr_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] seen[$];
    logic [7:0] e;
    b1.instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b1.imem_ack = b1.imem_req;
      b1.imem_rdata = mem[b1.imem_addr];
      if (b1.imem_req) seen.push_back(b1.imem_addr);
      tick();
    end
    b1.imem_ack = 1'b0;
    b1.instr_ready = 1'b0;
    checks++;
    if (seen.size() < 4) begin
      errors++;
      $display("FAIL wrap_count got=%0d exp=4", seen.size());
    end
    for (int k = 0; k < 4 && k < seen.size(); k++) begin
      e = 8'(8'hFE + k);
      checks++;
      if (seen[k] !== e) begin
        errors++;
        $display("FAIL wrap_addr%0d got=%h exp=%h", k, seen[k], e);
      end
    end
  endtask

  task automatic test_throughput();
    logic [7:0] e = 8'h00;
    int last = 0, n = 0;
    fixed_lat = 0;
    b0.instr_ready = 1'b1;
    b0.br_valid = 1'b1;
    b0.br_target = 8'h00;
    tick();
    b0.br_valid = 1'b0;
    for (int i = 0; i < 30 && n < 8; i++) begin
      if (b0.instr_valid) begin
        checks++;
        if (b0.instr_pc !== e) begin
          errors++;
          $display("FAIL tput_pc got=%h exp=%h", b0.instr_pc, e);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last !== GAP) begin
            errors++;
            $display("FAIL tput_gap got=%0d exp=%0d", cyc - last, GAP);
          end
        end
        last = cyc;
        e++;
        n++;
      end
      tick();
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL tput_count got=%0d exp=8", n);
    end
    b0.instr_ready = 1'b0;
    repeat (4) tick();
    checks++;
    if ({b0.imem_req, b0.instr_valid} !== 2'b01) begin
      errors++;
      $display("FAIL full_req_low got=%b exp=01", {b0.imem_req, b0.instr_valid});
    end
  endtask

  task automatic test_reset_midfetch();
    bit found = 1'b0;
    fixed_lat = 3;
    b0.br_valid = 1'b1;
    b0.br_target = 8'h10;
    tick();
    b0.br_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    fixed_lat = 1;
    checks++;
    if (b0.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_ack got=%b exp=0", b0.instr_valid);
    end
    checks++;
    if ({b0.imem_req, b0.imem_addr} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL rst_refetch got=%b/%h exp=1/00", b0.imem_req, b0.imem_addr);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (b0.instr_valid) found = 1'b1;
    end
    checks++;
    if ({found, b0.instr_pc, b0.opcode, b0.imm} !== {1'b1, 8'h00, 3'b100, 7'h50}) begin
      errors++;
      $display("FAIL rst_first got=%b/%h/%b/%h exp=1/00/100/50", found, b0.instr_pc, b0.opcode, b0.imm);
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    logic [15:0] w;
    logic [26:0] snap = '0;
    bit prev_hold = 1'b0;
    int accepts = 0;
    fixed_lat = -1;
    b0.instr_ready = 1'b0;
    b0.br_valid = 1'b1;
    b0.br_target = 8'($urandom);
    e = b0.br_target;
    tick();
    for (int i = 0; i < 800; i++) begin
      if (prev_hold) begin
        checks++;
        if ({b0.instr_valid, b0.opcode, b0.rs, b0.rt, b0.rd, b0.imm, b0.instr_pc} !== {1'b1, snap}) begin
          errors++;
          $display("FAIL rnd_stable got=%b/%h exp=1/%h", b0.instr_valid,
                   {b0.opcode, b0.rs, b0.rt, b0.rd, b0.imm, b0.instr_pc}, snap);
        end
      end
      b0.instr_ready = $urandom_range(0, 3) != 0;
      b0.br_valid = $urandom_range(0, 29) == 0;
      b0.br_target = 8'($urandom);
      if (b0.instr_valid && b0.instr_ready && !b0.br_valid) begin
        w = mem[e];
        checks++;
        if ({b0.instr_pc, b0.opcode, b0.rs, b0.rt, b0.rd, b0.imm} !==
            {e, w[15:13], w[12:10], w[9:7], w[6:4], w[6:0]}) begin
          errors++;
          $display("FAIL rnd_accept got=%h/%h exp=%h/%h", b0.instr_pc,
                   {b0.opcode, b0.rs, b0.rt, b0.rd, b0.imm}, e, {w[15:13], w[12:10], w[9:7], w[6:4], w[6:0]});
        end
        e++;
        accepts++;
      end
      if (b0.br_valid) e = b0.br_target;
      prev_hold = b0.instr_valid && !b0.instr_ready && !b0.br_valid;
      snap = {b0.opcode, b0.rs, b0.rt, b0.rd, b0.imm, b0.instr_pc};
      tick();
    end
    b0.br_valid = 1'b0;
    b0.instr_ready = 1'b0;
    checks++;
    if (accepts < 50) begin
      errors++;
      $display("FAIL rnd_progress got=%0d exp=>=50", accepts);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h8A50;
    b0.instr_ready = 1'b0;
    b0.br_valid = 1'b0;
    b0.br_target = '0;
    b1.imem_ack = 1'b0;
    b1.imem_rdata = '0;
    b1.instr_ready = 1'b0;
    b1.br_valid = 1'b0;
    b1.br_target = '0;
    test_reset();
    test_first_fetch();
    test_hold();
    test_branch_hold();
    test_branch_wait();
    test_wrap();
    test_throughput();
    test_reset_midfetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
